// File: rtl/hilo_reg_unit_pkg.sv
// Shared definitions for the HI/LO register unit: half selectors and
// long-op scoreboard state encodings.
package hilo_reg_unit_pkg;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  typedef enum logic [1:0] {
    HILO_IDLE = 2'd0,
    HILO_MUL  = 2'd1,
    HILO_DIV  = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/hilo_bypass_mux.sv
// Read-port source selection for MFHI/MFLO: a completing long-op result wins,
// then a same-cycle MT to the same half, then the architectural register.
module hilo_bypass_mux
  import hilo_reg_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                enable,
  input  logic                sel,
  input  logic                res_valid,
  input  logic [2*DATA_W-1:0] res,
  input  logic                mt_valid,
  input  logic                mt_sel,
  input  logic [DATA_W-1:0]   mt_data,
  input  logic [DATA_W-1:0]   hi,
  input  logic [DATA_W-1:0]   lo,
  output logic [DATA_W-1:0]   data
);

  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  assign res_hi = res[2*DATA_W-1:DATA_W];
  assign res_lo = res[DATA_W-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can leave it unassigned and infer a latch.
  always_comb begin
    data = '0;
    if (enable) begin
      if (res_valid) begin
        data = (sel == HILO_SEL_HI) ? res_hi : res_lo;
      end else if (mt_valid && (mt_sel == sel)) begin
        data = mt_data;
      end else begin
        data = (sel == HILO_SEL_HI) ? hi : lo;
      end
    end
  end

endmodule

// File: rtl/hilo_reg_unit.sv
// Architectural HI/LO pair: captures multiplier/divider results, serves MT/MF
// with same-cycle bypass, and stalls HI/LO accesses while a long op is in flight.
module hilo_reg_unit
  import hilo_reg_unit_pkg::*;
#(
  parameter int                 DATA_W = 32,
  parameter logic [DATA_W-1:0]  RST_HI = '0,
  parameter logic [DATA_W-1:0]  RST_LO = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cancel,
  input  logic                mul_issue,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_res,
  input  logic                div_issue,
  input  logic                div_done,
  input  logic [2*DATA_W-1:0] div_res,
  input  logic                mt_valid,
  input  logic                mt_sel,
  input  logic [DATA_W-1:0]   mt_data,
  output logic                mt_ready,
  input  logic                mf_valid,
  input  logic                mf_sel,
  output logic                mf_ready,
  output logic [DATA_W-1:0]   mf_data,
  output logic [2*DATA_W-1:0] hilo_data,
  output logic                busy
);

  hilo_state_e         state;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic                mul_fin;
  logic                div_fin;
  logic                done_now;
  logic [2*DATA_W-1:0] res_now;

  // A done only counts when it matches the op the scoreboard is waiting on.
  assign mul_fin  = (state == HILO_MUL) && mul_done;
  assign div_fin  = (state == HILO_DIV) && div_done;
  assign done_now = mul_fin || div_fin;
  assign res_now  = mul_fin ? mul_res : div_res;

  assign busy      = (state != HILO_IDLE);
  assign hilo_data = {hi_q, lo_q};

  // MT waits for IDLE, so it can never race a result write to the same half.
  assign mt_ready = mt_valid && !busy && !cancel && !rst;
  assign mf_ready = mf_valid && (!busy || done_now) && !cancel && !rst;

  hilo_bypass_mux #(
    .DATA_W (DATA_W)
  ) u_bypass (
    .enable    (mf_ready),
    .sel       (mf_sel),
    .res_valid (done_now),
    .res       (res_now),
    .mt_valid  (mt_ready),
    .mt_sel    (mt_sel),
    .mt_data   (mt_data),
    .hi        (hi_q),
    .lo        (lo_q),
    .data      (mf_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HILO_IDLE;
      hi_q  <= RST_HI;
      lo_q  <= RST_LO;
    end else if (cancel) begin
      state <= HILO_IDLE;
    end else begin
      if (done_now) begin
        hi_q <= res_now[2*DATA_W-1:DATA_W];
        lo_q <= res_now[DATA_W-1:0];
      end else if (mt_ready) begin
        if (mt_sel == HILO_SEL_HI) hi_q <= mt_data;
        else                       lo_q <= mt_data;
      end

      case (state)
        HILO_IDLE: begin
          if (mul_issue)      state <= HILO_MUL;
          else if (div_issue) state <= HILO_DIV;
        end
        HILO_MUL: begin
          if (mul_done) state <= mul_issue ? HILO_MUL : HILO_IDLE;
        end
        HILO_DIV: begin
          if (div_done) begin
            if (div_issue)      state <= HILO_DIV;
            else if (mul_issue) state <= HILO_MUL;
            else                state <= HILO_IDLE;
          end
        end
        default: state <= HILO_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_reg_unit.sv
// Directed bench for hilo_reg_unit: reset, MT/MF bypass, mul/div capture,
// cancel, MT stalling and back-to-back multiplies.
module tb_hilo_reg_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           cancel;
  logic           mul_issue;
  logic           mul_done;
  logic [2*W-1:0] mul_res;
  logic           div_issue;
  logic           div_done;
  logic [2*W-1:0] div_res;
  logic           mt_valid;
  logic           mt_sel;
  logic [W-1:0]   mt_data;
  logic           mt_ready;
  logic           mf_valid;
  logic           mf_sel;
  logic           mf_ready;
  logic [W-1:0]   mf_data;
  logic [2*W-1:0] hilo_data;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_reg_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cancel    (cancel),
    .mul_issue (mul_issue),
    .mul_done  (mul_done),
    .mul_res   (mul_res),
    .div_issue (div_issue),
    .div_done  (div_done),
    .div_res   (div_res),
    .mt_valid  (mt_valid),
    .mt_sel    (mt_sel),
    .mt_data   (mt_data),
    .mt_ready  (mt_ready),
    .mf_valid  (mf_valid),
    .mf_sel    (mf_sel),
    .mf_ready  (mf_ready),
    .mf_data   (mf_data),
    .hilo_data (hilo_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed right after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cancel = 1'b0;
    mul_issue = 1'b0; mul_done = 1'b0; mul_res = '0;
    div_issue = 1'b0; div_done = 1'b0; div_res = '0;
    mt_valid = 1'b1; mt_sel = 1'b0; mt_data = 32'hBAD0BAD0;
    mf_valid = 1'b1; mf_sel = 1'b1;

    // 1. Reset: requests present but nothing is accepted or written.
    tick();
    sample();
    check("rst_mt_ready", mt_ready, 0);
    check("rst_mf_ready", mf_ready, 0);
    check("rst_mf_data", mf_data, 0);
    tick();
    sample();
    check("rst_hilo", hilo_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; mt_valid = 1'b0; mf_valid = 1'b1; mf_sel = 1'b1;
    sample();
    check("idle_mfhi_ready", mf_ready, 1);
    check("idle_mfhi_data", mf_data, 0);
    tick();

    // 2. MTLO, MFLO, MTHI.
    mf_valid = 1'b0;
    mt_valid = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_1234;
    sample();
    check("mtlo_ready", mt_ready, 1);
    tick();
    mt_valid = 1'b0; mf_valid = 1'b1; mf_sel = 1'b0;
    sample();
    check("mflo_data", mf_data, 32'h0000_1234);
    check("mtlo_hilo", hilo_data, 64'h0000_0000_0000_1234);
    tick();
    mf_valid = 1'b0;
    mt_valid = 1'b1; mt_sel = 1'b1; mt_data = 32'hFFFF_0000;
    tick();
    mt_valid = 1'b0;
    sample();
    check("mthi_hilo", hilo_data, 64'hFFFF_0000_0000_1234);

    // Same-cycle MT and MF: bypass only when the halves match.
    mt_valid = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_5678;
    mf_valid = 1'b1; mf_sel = 1'b1;
    sample();
    check("mt_mf_diff_sel", mf_data, 32'hFFFF_0000);
    tick();
    mt_data = 32'h0000_1234; mf_sel = 1'b0;
    sample();
    check("mt_mf_same_sel", mf_data, 32'h0000_1234);
    tick();
    mt_valid = 1'b0; mf_valid = 1'b0;

    // A div_done while IDLE is ignored.
    div_done = 1'b1; div_res = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    div_done = 1'b0;
    sample();
    check("idle_done_ignored", hilo_data, 64'hFFFF_0000_0000_1234);

    // 3. Multiply with MFHI held across the wait.
    mul_issue = 1'b1;
    tick();
    mul_issue = 1'b0; mf_valid = 1'b1; mf_sel = 1'b1;
    sample();
    check("mul_busy", busy, 1);
    check("mul_wait1_mf_ready", mf_ready, 0);
    check("mul_wait1_mf_data", mf_data, 0);
    tick();
    sample();
    check("mul_wait2_mf_ready", mf_ready, 0);
    tick();
    mul_done = 1'b1; mul_res = 64'h0000_0002_0000_0003;
    sample();
    check("mul_done_mf_ready", mf_ready, 1);
    check("mul_done_bypass", mf_data, 32'h0000_0002);
    check("mul_done_hilo_old", hilo_data, 64'hFFFF_0000_0000_1234);
    tick();
    mul_done = 1'b0; mf_valid = 1'b0;
    sample();
    check("mul_hilo_new", hilo_data, 64'h0000_0002_0000_0003);
    check("mul_idle", busy, 0);

    // 4. Cancel in the done cycle discards the result and any MT.
    mul_issue = 1'b1;
    tick();
    mul_issue = 1'b0;
    tick();
    cancel = 1'b1; mul_done = 1'b1; mul_res = 64'h1111_1111_2222_2222;
    mt_valid = 1'b1; mt_sel = 1'b0; mt_data = 32'h0BAD_0BAD;
    mf_valid = 1'b1; mf_sel = 1'b0;
    sample();
    check("cancel_mt_ready", mt_ready, 0);
    check("cancel_mf_ready", mf_ready, 0);
    tick();
    cancel = 1'b0; mul_done = 1'b0; mt_valid = 1'b0;
    sample();
    check("cancel_busy", busy, 0);
    check("cancel_hilo", hilo_data, 64'h0000_0002_0000_0003);
    check("cancel_mflo", mf_data, 32'h0000_0003);
    tick();
    mf_valid = 1'b0;

    // 5. Divide with MTLO held: stalled until the cycle after div_done.
    div_issue = 1'b1;
    tick();
    div_issue = 1'b0;
    mt_valid = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_CAFE;
    sample();
    check("div_wait1_mt_ready", mt_ready, 0);
    tick();
    sample();
    check("div_wait2_mt_ready", mt_ready, 0);
    tick();
    div_done = 1'b1; div_res = 64'h0000_0007_0000_0009;
    sample();
    check("div_done_mt_ready", mt_ready, 0);
    tick();
    div_done = 1'b0;
    sample();
    check("div_hilo", hilo_data, 64'h0000_0007_0000_0009);
    check("div_after_mt_ready", mt_ready, 1);
    tick();
    mt_valid = 1'b0;
    sample();
    check("div_mt_overwrite", hilo_data, 64'h0000_0007_0000_CAFE);

    // 6. Back-to-back multiplies.
    mul_issue = 1'b1;
    tick();
    mul_issue = 1'b0;
    tick();
    mul_done = 1'b1; mul_res = 64'h0000_0010_0000_0020; mul_issue = 1'b1;
    sample();
    check("b2b_busy_done", busy, 1);
    tick();
    mul_done = 1'b0; mul_issue = 1'b0;
    for (int i = 1; i < 4; i++) begin
      sample();
      check($sformatf("b2b_hold_%0d", i), hilo_data, 64'h0000_0010_0000_0020);
      check($sformatf("b2b_busy_%0d", i), busy, 1);
      tick();
    end
    mul_done = 1'b1; mul_res = 64'h0000_0030_0000_0040;
    mf_valid = 1'b1; mf_sel = 1'b0;
    sample();
    check("b2b_bypass", mf_data, 32'h0000_0040);
    tick();
    mul_done = 1'b0; mf_valid = 1'b0;
    sample();
    check("b2b_hilo_second", hilo_data, 64'h0000_0030_0000_0040);
    check("b2b_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
